// File: rtl/geofence_pkg.sv
// Shared types, state encoding and width helpers for the geofence_n engine.
package geofence_pkg;

   localparam int COORD_W_DEF = 10;

   function automatic int diff_w(input int cw);
      return cw + 1;
   endfunction

   function automatic int prod_w(input int cw);
      return 2 * cw + 2;
   endfunction

   function automatic int cross_w(input int cw);
      return 2 * cw + 3;
   endfunction

   typedef struct packed {
      logic [COORD_W_DEF-1:0] x;
      logic [COORD_W_DEF-1:0] y;
   } point_t;

   typedef logic signed [2*COORD_W_DEF+2:0] cross_t;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SORT = 3'd2;
   localparam logic [2:0] S_TEST = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   typedef enum logic [2:0] {
      GF_IDLE = S_IDLE,
      GF_LOAD = S_LOAD,
      GF_SORT = S_SORT,
      GF_TEST = S_TEST,
      GF_DONE = S_DONE
   } gf_state_e;

endpackage

// File: rtl/geofence_n_if.sv
// Beat stream into geofence_n and result strobe out; area2 exists only with GEOFENCE_AREA_EN.
interface geofence_n_if #(
   parameter int COORD_W = 10,
   parameter int VCNT_W  = 4
);
   // in_valid/in_ready: a beat transfers on the rising edge where both are high; beats offered
   // while in_ready is low are dropped, not queued. valid is a one-cycle strobe with no back-pressure.
   logic               in_valid;
   logic               in_ready;
   logic [VCNT_W-1:0]  n_vert;
   logic [COORD_W-1:0] X;
   logic [COORD_W-1:0] Y;
   logic               valid;
   logic               is_inside;
`ifdef GEOFENCE_AREA_EN
   logic [2*COORD_W+VCNT_W:0] area2;

   modport master (output in_valid, n_vert, X, Y, input in_ready, valid, is_inside, area2);
   modport slave  (input in_valid, n_vert, X, Y, output in_ready, valid, is_inside, area2);
`else
   modport master (output in_valid, n_vert, X, Y, input in_ready, valid, is_inside);
   modport slave  (input in_valid, n_vert, X, Y, output in_ready, valid, is_inside);
`endif
endinterface

// File: rtl/geofence_cross.sv
// Combinational 2-D cross product ax*by - ay*bx of two signed difference vectors.
module geofence_cross
   import geofence_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic signed [diff_w(COORD_W)-1:0]  ax_i,
   input  logic signed [diff_w(COORD_W)-1:0]  ay_i,
   input  logic signed [diff_w(COORD_W)-1:0]  bx_i,
   input  logic signed [diff_w(COORD_W)-1:0]  by_i,
   output logic signed [cross_w(COORD_W)-1:0] c_o
);
   localparam int CW = cross_w(COORD_W);

   logic signed [prod_w(COORD_W)-1:0] p_ab;
   logic signed [prod_w(COORD_W)-1:0] p_ba;

   assign p_ab = ax_i * by_i;
   assign p_ba = ay_i * bx_i;
   assign c_o  = CW'(p_ab) - CW'(p_ba);
endmodule

// File: rtl/geofence_n.sv
// geofence_n: sorts up to MAX_VERT convex vertices CCW about V0, then tests P strictly inside.
// Define GEOFENCE_AREA_EN to add the shoelace accumulator and the area2 result.
module geofence_n
   import geofence_pkg::*;
#(
   parameter int COORD_W  = COORD_W_DEF,
   parameter int MAX_VERT = 8,
   parameter int VCNT_W   = $clog2(MAX_VERT + 1)
) (
   input  logic        clk,
   input  logic        reset,
   geofence_n_if.slave bus,
   output gf_state_e   state_o
);
   localparam int DW = diff_w(COORD_W);
   localparam int CW = cross_w(COORD_W);
   localparam int IW = $clog2(MAX_VERT);
   localparam logic [VCNT_W-1:0] MAXV  = VCNT_W'(MAX_VERT);
   localparam logic [VCNT_W-1:0] ONE   = VCNT_W'(1);
   localparam logic [VCNT_W-1:0] TWO   = VCNT_W'(2);
   localparam logic [VCNT_W-1:0] THREE = VCNT_W'(3);

   gf_state_e          state_q, state_d;
   logic [VCNT_W-1:0]  n_q, n_d, cnt_q, cnt_d, pass_q, pass_d, n_in;
   logic               out_q, out_d, inside_q, inside_d;
   logic               p_en, ld_en, swap_en, le;
   logic [COORD_W-1:0] px_q, py_q;
   logic [COORD_W-1:0] vx_q [MAX_VERT];
   logic [COORD_W-1:0] vy_q [MAX_VERT];
   logic [IW-1:0]      ia, ib;
   logic [COORD_W-1:0] base_x, base_y, ta_x, ta_y, tb_x, tb_y;
   logic signed [DW-1:0] ax, ay, bx, by;
   logic signed [CW-1:0] cross_c;

   function automatic logic signed [DW-1:0] dif(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] q);
      return $signed({1'b0, p}) - $signed({1'b0, q});
   endfunction

   assign n_in = (bus.n_vert > MAXV) ? MAXV : bus.n_vert;

   // SORT compares (Vj, Vj+1) about V0; TEST walks edge (Vk, Vk+1 mod N) against P.
   always_comb begin
      ia = IW'(cnt_q);
      ib = IW'(cnt_q + ONE);
      if (state_q == GF_TEST && cnt_q == n_q - ONE) ib = '0;
   end

   always_comb begin
      base_x = vx_q[0];
      base_y = vy_q[0];
      ta_x   = vx_q[ia];
      ta_y   = vy_q[ia];
      tb_x   = vx_q[ib];
      tb_y   = vy_q[ib];
      if (state_q == GF_TEST) begin
         base_x = vx_q[ia];
         base_y = vy_q[ia];
         ta_x   = vx_q[ib];
         ta_y   = vy_q[ib];
         tb_x   = px_q;
         tb_y   = py_q;
      end
   end

   assign ax = dif(ta_x, base_x);
   assign ay = dif(ta_y, base_y);
   assign bx = dif(tb_x, base_x);
   assign by = dif(tb_y, base_y);

   geofence_cross #(.COORD_W(COORD_W)) u_cross (
      .ax_i(ax), .ay_i(ay), .bx_i(bx), .by_i(by), .c_o(cross_c)
   );

   assign le = cross_c[CW-1] || (cross_c == '0);

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      out_d    = out_q;
      inside_d = inside_q;
      p_en     = 1'b0;
      ld_en    = 1'b0;
      swap_en  = 1'b0;
      case (state_q)
         GF_IDLE: if (bus.in_valid) begin
            p_en   = 1'b1;
            n_d    = n_in;
            cnt_d  = '0;
            pass_d = '0;
            out_d  = 1'b0;
            if (n_in == '0) begin
               state_d  = GF_DONE;
               inside_d = 1'b0;
            end else begin
               state_d = GF_LOAD;
            end
         end
         GF_LOAD: if (bus.in_valid) begin
            ld_en = 1'b1;
            cnt_d = cnt_q + ONE;
            if (cnt_q == n_q - ONE) begin
               if (n_q < THREE) begin
                  state_d  = GF_DONE;
                  inside_d = 1'b0;
               end else begin
                  state_d = GF_SORT;
                  cnt_d   = ONE;
               end
            end
         end
         GF_SORT: begin
            swap_en = cross_c[CW-1];
            if (cnt_q == n_q - TWO) begin
               cnt_d  = ONE;
               pass_d = pass_q + ONE;
               if (pass_q == n_q - THREE) begin
                  state_d = GF_TEST;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         GF_TEST: begin
            out_d = out_q | le;
            cnt_d = cnt_q + ONE;
            if (cnt_q == n_q - ONE) begin
               state_d  = GF_DONE;
               inside_d = !out_d;
            end
         end
         GF_DONE: state_d = GF_IDLE;
         default: state_d = GF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= GF_IDLE;
         n_q      <= '0;
         cnt_q    <= '0;
         pass_q   <= '0;
         out_q    <= 1'b0;
         inside_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         out_q    <= out_d;
         inside_q <= inside_d;
      end
   end

   // Point and vertex storage carry no reset; their contents are rewritten per object.
   always_ff @(posedge clk) begin
      if (p_en) begin
         px_q <= bus.X;
         py_q <= bus.Y;
      end
      if (ld_en) begin
         vx_q[IW'(cnt_q)] <= bus.X;
         vy_q[IW'(cnt_q)] <= bus.Y;
      end else if (swap_en) begin
         vx_q[ia] <= vx_q[ib];
         vx_q[ib] <= vx_q[ia];
         vy_q[ia] <= vy_q[ib];
         vy_q[ib] <= vy_q[ia];
      end
   end

`ifdef GEOFENCE_AREA_EN
   localparam int AW  = 2 * COORD_W + VCNT_W + 1;
   localparam int AW1 = AW + 1;

   logic signed [CW-1:0] term_c;
   logic signed [AW:0]   acc_q, acc_d;
   logic [AW-1:0]        area_q, area_d;

   geofence_cross #(.COORD_W(COORD_W)) u_area (
      .ax_i($signed({1'b0, vx_q[ia]})), .ay_i($signed({1'b0, vy_q[ia]})),
      .bx_i($signed({1'b0, vx_q[ib]})), .by_i($signed({1'b0, vy_q[ib]})),
      .c_o (term_c)
   );

   always_comb begin
      acc_d  = '0;
      area_d = area_q;
      if (state_q == GF_TEST) acc_d = acc_q + AW1'(term_c);
      if (state_d == GF_DONE) begin
         if (state_q != GF_TEST) area_d = '0;
         else area_d = acc_d[AW] ? AW'(-acc_d) : AW'(acc_d);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         area_q <= '0;
      end else begin
         acc_q  <= acc_d;
         area_q <= area_d;
      end
   end

   assign bus.area2 = area_q;
`endif

   assign bus.in_ready  = (state_q == GF_IDLE) || (state_q == GF_LOAD);
   assign bus.valid     = (state_q == GF_DONE);
   assign bus.is_inside = inside_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_geofence_n.sv
// Directed-vector bench for geofence_n; area2 checks are compiled in with GEOFENCE_AREA_EN.
module tb_geofence_n;
   import geofence_pkg::*;

   logic      clk = 1'b0;
   logic      reset;
   gf_state_e state;
   int        checks = 0;
   int        errors = 0;
   point_t    vbuf [8];

   geofence_n_if #(.COORD_W(10), .VCNT_W(4)) bus ();

   geofence_n #(.COORD_W(10), .MAX_VERT(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .state_o(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_v(input int i, input int x, input int y);
      vbuf[i].x = 10'(x);
      vbuf[i].y = 10'(y);
   endtask

   task automatic set_square();
      set_v(0, 100, 100);
      set_v(1, 0, 0);
      set_v(2, 0, 100);
      set_v(3, 100, 0);
   endtask

   task automatic send_beat(input int x, input int y, input int nv, input int stall);
      int g = 0;
      bus.in_valid = 1'b0;
      repeat (stall) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.X        = 10'(x);
      bus.Y        = 10'(y);
      bus.n_vert   = 4'(nv);
      while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
      if (g >= 100) check_eq("rdy_timeout", 32'(g), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_obj(input int px, input int py, input int nv, input int nbeats,
                           input int stall);
      send_beat(px, py, nv, 0);
      for (int i = 0; i < nbeats; i++) send_beat(int'(vbuf[i].x), int'(vbuf[i].y), nv, stall);
   endtask

   // Called one cycle after the last vertex edge, so that edge already counts as 1.
   task automatic wait_result(input string tag, input int exp_lat, input logic exp_in,
                              input int hold);
      int n = 1;
      if (hold > 0) begin
         bus.in_valid = 1'b1;
         bus.X        = 10'd999;
         bus.Y        = 10'd999;
         bus.n_vert   = 4'd3;
      end
      while (!bus.valid && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (n == hold) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check_eq({tag, "_in"}, 32'(bus.is_inside), 32'(exp_in));
      @(posedge clk); #1;
      check_eq({tag, "_vlo"}, 32'(bus.valid), 32'd0);
      check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      check_eq({tag, "_hold"}, 32'(bus.is_inside), 32'(exp_in));
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.X        = '0;
      bus.Y        = '0;
      bus.n_vert   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst_inside", 32'(bus.is_inside), 32'd0);
      check_eq("rst_state", 32'(state), 32'(GF_IDLE));
`ifdef GEOFENCE_AREA_EN
      check_eq("rst_area", 32'(bus.area2), 32'd0);
`endif

      set_square();
      send_obj(50, 50, 4, 4, 0);
      wait_result("sq_in", 9, 1'b1, 0);
`ifdef GEOFENCE_AREA_EN
      check_eq("sq_area", 32'(bus.area2), 32'd20000);
`endif
      send_obj(150, 50, 4, 4, 0);
      wait_result("sq_out", 9, 1'b0, 0);
      send_obj(100, 50, 4, 4, 0);
      wait_result("sq_edge", 9, 1'b0, 0);

      set_v(0, 100, 150);
      set_v(1, 100, 250);
      set_v(2, 200, 300);
      set_v(3, 300, 250);
      set_v(4, 300, 150);
      set_v(5, 200, 100);
      send_obj(200, 200, 6, 6, 0);
      wait_result("hex", 23, 1'b1, 20);
`ifdef GEOFENCE_AREA_EN
      check_eq("hex_area", 32'(bus.area2), 32'd60000);
`endif

      set_v(0, 10, 10);
      set_v(1, 20, 20);
      send_obj(15, 15, 2, 2, 0);
      wait_result("n2", 1, 1'b0, 0);
`ifdef GEOFENCE_AREA_EN
      check_eq("n2_area", 32'(bus.area2), 32'd0);
`endif

      set_v(0, 100, 0);
      set_v(1, 300, 200);
      set_v(2, 0, 100);
      set_v(3, 200, 0);
      set_v(4, 100, 300);
      set_v(5, 300, 100);
      set_v(6, 0, 200);
      set_v(7, 200, 300);
      send_obj(150, 150, 12, 8, 0);
      check_eq("clamp_busy", 32'(bus.in_ready), 32'd0);
      wait_result("oct", 45, 1'b1, 0);
`ifdef GEOFENCE_AREA_EN
      check_eq("oct_area", 32'(bus.area2), 32'd140000);
`endif

      set_square();
      send_obj(50, 50, 4, 4, 0);
      @(posedge clk); #1;
      check_eq("mid_sort", 32'(state), 32'(GF_SORT));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("abort_valid", 32'(bus.valid), 32'd0);
      check_eq("abort_ready", 32'(bus.in_ready), 32'd1);
      send_obj(50, 50, 4, 4, 0);
      wait_result("post_rst", 9, 1'b1, 0);

      send_obj(50, 50, 4, 4, 2);
      wait_result("b2b_a", 9, 1'b1, 0);
      send_obj(150, 50, 4, 4, 3);
      wait_result("b2b_b", 9, 1'b0, 0);
`ifdef GEOFENCE_AREA_EN
      check_eq("b2b_area", 32'(bus.area2), 32'd20000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
